// File: rtl/traffic_phase_controller.sv
// Single-lamp traffic phase sequencer: seconds prescaler, per-phase countdown,
// flashing-yellow safe mode and a two-digit BCD view of the remaining time.
module traffic_phase_controller #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic [6:0] green_time,
  input  logic [6:0] yellow_time,
  input  logic [6:0] red_time,
  input  logic [2:0] alert_time,
  output logic [2:0] light,
  output logic [1:0] phase,
  output logic [6:0] remain,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones,
  output logic       fault
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_FLASH  = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_RED    = 2'd3
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_blink;
  logic [2:0]    r_light;
  logic [6:0]    r_remain;

  logic          w_tick;
  logic          w_alert;
  logic [PW-1:0] w_presc_nxt;

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_alert     = |alert_time;
  assign w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);

  // State, prescaler and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FLASH;
      r_presc  <= '0;
      r_blink  <= 1'b1;
      r_light  <= 3'b010;
      r_remain <= 7'd0;
    end else if (set_mode) begin
      r_state  <= S_FLASH;
      r_presc  <= '0;
      r_blink  <= 1'b1;
      r_light  <= 3'b010;
      r_remain <= 7'd0;
    end else if (r_state == S_FLASH) begin
      if (w_alert) begin
        r_presc <= w_presc_nxt;
        if (w_tick) begin
          r_blink <= ~r_blink;
          r_light <= {1'b0, ~r_blink, 1'b0};
        end
      end else begin
        r_state  <= S_RED;
        r_presc  <= '0;
        r_light  <= 3'b100;
        r_remain <= red_time;
      end
    end else if (w_alert) begin
      r_state  <= S_FLASH;
      r_presc  <= '0;
      r_blink  <= 1'b1;
      r_light  <= 3'b010;
      r_remain <= 7'd0;
    end else begin
      r_presc <= w_presc_nxt;
      if (w_tick) begin
        // Treat 0 like 1 so an unexpected zero duration cannot wrap the count
        if (r_remain > 7'd1) begin
          r_remain <= r_remain - 7'd1;
        end else begin
          case (r_state)
            S_GREEN: begin
              r_state  <= S_YELLOW;
              r_light  <= 3'b010;
              r_remain <= yellow_time;
            end
            S_YELLOW: begin
              r_state  <= S_RED;
              r_light  <= 3'b100;
              r_remain <= red_time;
            end
            S_RED: begin
              r_state  <= S_GREEN;
              r_light  <= 3'b001;
              r_remain <= green_time;
            end
            default: begin
              r_state  <= S_FLASH;
              r_blink  <= 1'b1;
              r_light  <= 3'b010;
              r_remain <= 7'd0;
            end
          endcase
        end
      end
    end
  end

  assign light       = r_light;
  assign phase       = r_state;
  assign remain      = r_remain;
  assign remain_tens = 4'(r_remain / 7'd10);
  assign remain_ones = 4'(r_remain % 7'd10);
  assign fault       = (r_state == S_FLASH) & ~set_mode & w_alert;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller at TICK_DIV=4: vector table for
// the main sequence, hand sequences for async reset and one-second phases.
module tb_traffic_phase_controller;

  localparam int unsigned TD = 4;

  logic       clk;
  logic       rst;
  logic       set_mode;
  logic [6:0] green_time;
  logic [6:0] yellow_time;
  logic [6:0] red_time;
  logic [2:0] alert_time;
  logic [2:0] light;
  logic [1:0] phase;
  logic [6:0] remain;
  logic [3:0] remain_tens;
  logic [3:0] remain_ones;
  logic       fault;

  int total;
  int bad;

  traffic_phase_controller #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .set_mode    (set_mode),
    .green_time  (green_time),
    .yellow_time (yellow_time),
    .red_time    (red_time),
    .alert_time  (alert_time),
    .light       (light),
    .phase       (phase),
    .remain      (remain),
    .remain_tens (remain_tens),
    .remain_ones (remain_ones),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sm;
    logic [2:0] al;
    logic [6:0] rt;
    int         adv;
    logic [1:0] ph;
    logic [2:0] lt;
    logic [6:0] rem;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       flt;
  } vec_t;

  localparam int NV = 28;
  vec_t vt[NV];

  function automatic vec_t mk(logic sm, logic [2:0] al, logic [6:0] rt, int adv,
                              logic [1:0] ph, logic [2:0] lt, logic [6:0] rem,
                              logic [3:0] tens, logic [3:0] ones, logic flt);
    vec_t v;
    v.sm = sm; v.al = al; v.rt = rt; v.adv = adv; v.ph = ph; v.lt = lt;
    v.rem = rem; v.tens = tens; v.ones = ones; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [1:0] ph, input logic [2:0] lt,
                         input logic [6:0] rem, input logic [3:0] tens,
                         input logic [3:0] ones, input logic flt);
    chk("phase", idx, int'(phase), int'(ph));
    chk("light", idx, int'(light), int'(lt));
    chk("remain", idx, int'(remain), int'(rem));
    chk("tens", idx, int'(remain_tens), int'(tens));
    chk("ones", idx, int'(remain_ones), int'(ones));
    chk("fault", idx, int'(fault), int'(flt));
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Phase: 0 FLASH, 1 GREEN, 2 YELLOW, 3 RED
    vt[0]  = mk(0, 3'b111,  7'd7,   0, 2'd0, 3'b010, 7'd0,  4'd0, 4'd0, 1);
    vt[1]  = mk(0, 3'b111,  7'd7,   3, 2'd0, 3'b010, 7'd0,  4'd0, 4'd0, 1);
    vt[2]  = mk(0, 3'b111,  7'd7,   1, 2'd0, 3'b000, 7'd0,  4'd0, 4'd0, 1);
    vt[3]  = mk(0, 3'b111,  7'd7,   4, 2'd0, 3'b010, 7'd0,  4'd0, 4'd0, 1);
    vt[4]  = mk(0, 3'b000,  7'd7,   1, 2'd3, 3'b100, 7'd7,  4'd0, 4'd7, 0);
    vt[5]  = mk(0, 3'b000,  7'd7,   3, 2'd3, 3'b100, 7'd7,  4'd0, 4'd7, 0);
    vt[6]  = mk(0, 3'b000,  7'd7,   1, 2'd3, 3'b100, 7'd6,  4'd0, 4'd6, 0);
    vt[7]  = mk(0, 3'b000,  7'd7,  20, 2'd3, 3'b100, 7'd1,  4'd0, 4'd1, 0);
    vt[8]  = mk(0, 3'b000,  7'd7,   3, 2'd3, 3'b100, 7'd1,  4'd0, 4'd1, 0);
    vt[9]  = mk(0, 3'b000,  7'd7,   1, 2'd1, 3'b001, 7'd5,  4'd0, 4'd5, 0);
    vt[10] = mk(0, 3'b000,  7'd7,  19, 2'd1, 3'b001, 7'd1,  4'd0, 4'd1, 0);
    vt[11] = mk(0, 3'b000,  7'd7,   1, 2'd2, 3'b010, 7'd3,  4'd0, 4'd3, 0);
    vt[12] = mk(0, 3'b000,  7'd7,  12, 2'd3, 3'b100, 7'd7,  4'd0, 4'd7, 0);
    // Mid-phase duration change must not disturb the running RED
    vt[13] = mk(0, 3'b000, 7'd42,  27, 2'd3, 3'b100, 7'd1,  4'd0, 4'd1, 0);
    vt[14] = mk(0, 3'b000, 7'd42,   1, 2'd1, 3'b001, 7'd5,  4'd0, 4'd5, 0);
    vt[15] = mk(0, 3'b000, 7'd42,  32, 2'd3, 3'b100, 7'd42, 4'd4, 4'd2, 0);
    vt[16] = mk(0, 3'b000, 7'd42,   4, 2'd3, 3'b100, 7'd41, 4'd4, 4'd1, 0);
    vt[17] = mk(0, 3'b000, 7'd42, 164, 2'd1, 3'b001, 7'd5,  4'd0, 4'd5, 0);
    vt[18] = mk(0, 3'b000, 7'd42,   8, 2'd1, 3'b001, 7'd3,  4'd0, 4'd3, 0);
    vt[19] = mk(1, 3'b000, 7'd42,   1, 2'd0, 3'b010, 7'd0,  4'd0, 4'd0, 0);
    vt[20] = mk(1, 3'b000, 7'd42,  10, 2'd0, 3'b010, 7'd0,  4'd0, 4'd0, 0);
    vt[21] = mk(0, 3'b000,  7'd7,   1, 2'd3, 3'b100, 7'd7,  4'd0, 4'd7, 0);
    vt[22] = mk(0, 3'b000,  7'd7,  48, 2'd2, 3'b010, 7'd3,  4'd0, 4'd3, 0);
    vt[23] = mk(0, 3'b000,  7'd7,  11, 2'd2, 3'b010, 7'd1,  4'd0, 4'd1, 0);
    // set_mode on the final YELLOW tick: FLASH beats RED
    vt[24] = mk(1, 3'b000,  7'd7,   1, 2'd0, 3'b010, 7'd0,  4'd0, 4'd0, 0);
    vt[25] = mk(0, 3'b000,  7'd7,   1, 2'd3, 3'b100, 7'd7,  4'd0, 4'd7, 0);
    vt[26] = mk(0, 3'b010,  7'd7,   1, 2'd0, 3'b010, 7'd0,  4'd0, 4'd0, 1);
    vt[27] = mk(0, 3'b000,  7'd7,   1, 2'd3, 3'b100, 7'd7,  4'd0, 4'd7, 0);

    rst         = 1'b1;
    set_mode    = 1'b0;
    green_time  = 7'd5;
    yellow_time = 7'd3;
    red_time    = 7'd7;
    alert_time  = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      set_mode   = vt[i].sm;
      alert_time = vt[i].al;
      red_time   = vt[i].rt;
      if (vt[i].adv == 0) #1;
      else adv(vt[i].adv);
      chk_all(i, vt[i].ph, vt[i].lt, vt[i].rem, vt[i].tens, vt[i].ones, vt[i].flt);
    end

    // Asynchronous reset in the middle of YELLOW
    adv(48);
    chk_all(100, 2'd2, 3'b010, 7'd3, 4'd0, 4'd3, 0);
    adv(2);
    #2;
    rst = 1'b1;
    #1;
    chk_all(101, 2'd0, 3'b010, 7'd0, 4'd0, 4'd0, 0);

    // One-second phases, entered fresh after reset release
    green_time  = 7'd1;
    yellow_time = 7'd1;
    red_time    = 7'd1;
    #1;
    rst = 1'b0;
    adv(1);
    chk_all(102, 2'd3, 3'b100, 7'd1, 4'd0, 4'd1, 0);
    adv(3);
    chk_all(103, 2'd3, 3'b100, 7'd1, 4'd0, 4'd1, 0);
    adv(1);
    chk_all(104, 2'd1, 3'b001, 7'd1, 4'd0, 4'd1, 0);
    adv(4);
    chk_all(105, 2'd2, 3'b010, 7'd1, 4'd0, 4'd1, 0);
    adv(4);
    chk_all(106, 2'd3, 3'b100, 7'd1, 4'd0, 4'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
